// File: rtl/cache_nway_wb.sv
`default_nettype none
// ============================================================================
// Module   : cache_nway_wb
// Purpose  : N-way set-associative, write-back, write-allocate data cache.
//            Per-set age-based LRU, stalling miss FSM (IDLE/WB/REFILL) and a
//            ready-handshaked line-wide memory port with registered requests.
// Options  : CACHE_STATS_EN adds saturating hit_count / miss_count ports.
// Revision : 1.0 - initial release
// ============================================================================
module cache_nway_wb #(
    parameter int DATA_WIDTH      = 32,
    parameter int ADDR_WIDTH      = 32,
    parameter int NUM_WAYS        = 2,
    parameter int NUM_SETS        = 4,
    parameter int WORDS_PER_BLOCK = 4
) (
    input  logic                                  clk,
    input  logic                                  rst,
    input  logic                                  rd_en,
    input  logic                                  wr_en,
    input  logic [ADDR_WIDTH-1:0]                 addr,
    input  logic [DATA_WIDTH-1:0]                 WriteData,
    input  logic [2:0]                            funct3,
    output logic [DATA_WIDTH-1:0]                 cache_read,
    output logic                                  hit,
    output logic                                  stall,
    output logic                                  mem_req,
    output logic                                  mem_we,
    output logic [ADDR_WIDTH-1:0]                 mem_addr,
    output logic [WORDS_PER_BLOCK*DATA_WIDTH-1:0] mem_wdata,
    input  logic                                  mem_ready,
    input  logic [WORDS_PER_BLOCK*DATA_WIDTH-1:0] mem_rdata
`ifdef CACHE_STATS_EN
    ,
    output logic [31:0]                           hit_count,
    output logic [31:0]                           miss_count
`endif
);

    localparam int c_WORD_BITS = $clog2(WORDS_PER_BLOCK);
    localparam int c_WIDX_W    = (c_WORD_BITS > 0) ? c_WORD_BITS : 1;
    localparam int c_SET_BITS  = $clog2(NUM_SETS);
    localparam int c_WAY_BITS  = $clog2(NUM_WAYS);
    localparam int c_OFF_BITS  = 2 + c_WORD_BITS;
    localparam int c_TAG_BITS  = ADDR_WIDTH - c_OFF_BITS - c_SET_BITS;
    localparam int c_LINE_W    = WORDS_PER_BLOCK * DATA_WIDTH;
    localparam logic [c_OFF_BITS-1:0] c_ZERO_OFF = '0;

    localparam logic [1:0] c_IDLE   = 2'd0;
    localparam logic [1:0] c_WB     = 2'd1;
    localparam logic [1:0] c_REFILL = 2'd2;

    // Storage and per-line state
    logic [DATA_WIDTH-1:0] r_data  [NUM_SETS][NUM_WAYS][WORDS_PER_BLOCK];
    logic [c_TAG_BITS-1:0] r_tag   [NUM_SETS][NUM_WAYS];
    logic                  r_valid [NUM_SETS][NUM_WAYS];
    logic                  r_dirty [NUM_SETS][NUM_WAYS];
    logic [c_WAY_BITS-1:0] r_age   [NUM_SETS][NUM_WAYS];

    logic [1:0]            r_state;
    logic [c_WAY_BITS-1:0] r_victim;

    // Address fields
    logic [c_SET_BITS-1:0] w_set;
    logic [c_TAG_BITS-1:0] w_tag;
    logic [c_WIDX_W-1:0]   w_word;
    logic [1:0]            w_boff;
    logic [ADDR_WIDTH-1:0] w_fill_addr;

    assign w_set       = addr[c_OFF_BITS +: c_SET_BITS];
    assign w_tag       = addr[ADDR_WIDTH-1 -: c_TAG_BITS];
    assign w_boff      = addr[1:0];
    assign w_fill_addr = {w_tag, w_set, c_ZERO_OFF};

    generate
        if (c_WORD_BITS > 0) begin : g_word_idx
            assign w_word = addr[2 +: c_WIDX_W];
        end else begin : g_word_zero
            assign w_word = '0;
        end
    endgenerate

    logic                  w_idle, w_access, w_miss;
    logic                  w_hit_any;
    logic [c_WAY_BITS-1:0] w_hit_way;
    logic [c_WAY_BITS-1:0] w_lru_way, w_inv_way, w_victim;
    logic                  w_inv_found;
    logic [c_LINE_W-1:0]   w_victim_line;
    logic [DATA_WIDTH-1:0] w_rd_word, w_load, w_store_word;
    logic [7:0]            w_byte;
    logic [15:0]           w_half;
    logic [c_WAY_BITS-1:0] w_acc_way, w_acc_age;
    logic                  w_lru_upd;

    assign w_idle   = (r_state == c_IDLE);
    assign w_access = rd_en | wr_en;
    assign w_miss   = w_idle & w_access & ~w_hit_any;

    // Tag match across the ways of the addressed set
    always_comb begin
        w_hit_any = 1'b0;
        w_hit_way = '0;
        for (int w = 0; w < NUM_WAYS; w++) begin
            if (r_valid[w_set][w] && (r_tag[w_set][w] == w_tag)) begin
                w_hit_any = 1'b1;
                w_hit_way = c_WAY_BITS'(w);
            end
        end
    end

    // Victim: lowest-index invalid way, otherwise the oldest (max age) way
    always_comb begin
        w_lru_way   = '0;
        w_inv_way   = '0;
        w_inv_found = 1'b0;
        for (int w = 0; w < NUM_WAYS; w++) begin
            if (r_age[w_set][w] == c_WAY_BITS'(NUM_WAYS - 1)) begin
                w_lru_way = c_WAY_BITS'(w);
            end
        end
        for (int w = NUM_WAYS - 1; w >= 0; w--) begin
            if (!r_valid[w_set][w]) begin
                w_inv_found = 1'b1;
                w_inv_way   = c_WAY_BITS'(w);
            end
        end
        w_victim = w_inv_found ? w_inv_way : w_lru_way;
    end

    generate
        for (genvar g = 0; g < WORDS_PER_BLOCK; g++) begin : g_pack
            assign w_victim_line[g*DATA_WIDTH +: DATA_WIDTH] = r_data[w_set][w_victim][g];
        end
    endgenerate

    assign w_rd_word = r_data[w_set][w_hit_way][w_word];
    assign w_byte    = w_rd_word[{w_boff, 3'b000} +: 8];
    assign w_half    = w_rd_word[{w_boff[1], 4'b0000} +: 16];

    // Load extraction and store byte-lane merge
    always_comb begin
        case (funct3)
            3'b000:  w_load = {{(DATA_WIDTH-8){w_byte[7]}}, w_byte};
            3'b001:  w_load = {{(DATA_WIDTH-16){w_half[15]}}, w_half};
            3'b100:  w_load = {{(DATA_WIDTH-8){1'b0}}, w_byte};
            3'b101:  w_load = {{(DATA_WIDTH-16){1'b0}}, w_half};
            default: w_load = w_rd_word;
        endcase
        w_store_word = w_rd_word;
        case (funct3)
            3'b000:  w_store_word[{w_boff, 3'b000} +: 8]     = WriteData[7:0];
            3'b001:  w_store_word[{w_boff[1], 4'b0000} +: 16] = WriteData[15:0];
            default: w_store_word = WriteData;
        endcase
    end

    assign hit        = ~rst & w_idle & w_access & w_hit_any;
    assign stall      = ~rst & (~w_idle | (w_access & ~w_hit_any));
    assign cache_read = (hit & ~wr_en) ? w_load : '0;

    assign w_acc_way = (r_state == c_REFILL) ? r_victim : w_hit_way;
    assign w_acc_age = r_age[w_set][w_acc_way];
    assign w_lru_upd = hit | ((r_state == c_REFILL) & mem_ready);

    // Miss FSM, line state and LRU ages; ages reset to way index so they start as a permutation
    always_ff @(posedge clk) begin
        if (rst) begin
            r_state   <= c_IDLE;
            r_victim  <= '0;
            mem_req   <= 1'b0;
            mem_we    <= 1'b0;
            mem_addr  <= '0;
            mem_wdata <= '0;
            for (int s = 0; s < NUM_SETS; s++) begin
                for (int w = 0; w < NUM_WAYS; w++) begin
                    r_valid[s][w] <= 1'b0;
                    r_dirty[s][w] <= 1'b0;
                    r_tag[s][w]   <= '0;
                    r_age[s][w]   <= c_WAY_BITS'(w);
                end
            end
        end else begin
            if (w_lru_upd) begin
                for (int w = 0; w < NUM_WAYS; w++) begin
                    if (c_WAY_BITS'(w) == w_acc_way) begin
                        r_age[w_set][w] <= '0;
                    end else if (r_age[w_set][w] < w_acc_age) begin
                        r_age[w_set][w] <= r_age[w_set][w] + c_WAY_BITS'(1);
                    end
                end
            end
            case (r_state)
                c_IDLE: begin
                    if (hit && wr_en) begin
                        r_dirty[w_set][w_hit_way] <= 1'b1;
                    end
                    if (w_miss) begin
                        r_victim <= w_victim;
                        mem_req  <= 1'b1;
                        if (r_valid[w_set][w_victim] && r_dirty[w_set][w_victim]) begin
                            r_state   <= c_WB;
                            mem_we    <= 1'b1;
                            mem_addr  <= {r_tag[w_set][w_victim], w_set, c_ZERO_OFF};
                            mem_wdata <= w_victim_line;
                        end else begin
                            r_state  <= c_REFILL;
                            mem_we   <= 1'b0;
                            mem_addr <= w_fill_addr;
                        end
                    end
                end
                c_WB: begin
                    if (mem_ready) begin
                        r_state  <= c_REFILL;
                        mem_we   <= 1'b0;
                        mem_addr <= w_fill_addr;
                    end
                end
                c_REFILL: begin
                    if (mem_ready) begin
                        r_state                  <= c_IDLE;
                        mem_req                  <= 1'b0;
                        r_valid[w_set][r_victim] <= 1'b1;
                        r_dirty[w_set][r_victim] <= 1'b0;
                        r_tag[w_set][r_victim]   <= w_tag;
                    end
                end
                default: r_state <= c_IDLE;
            endcase
        end
    end

    // Data array: store-hit merge or full-line refill (contents need no reset)
    always_ff @(posedge clk) begin
        if (!rst) begin
            if (hit && wr_en) begin
                r_data[w_set][w_hit_way][w_word] <= w_store_word;
            end else if ((r_state == c_REFILL) && mem_ready) begin
                for (int g = 0; g < WORDS_PER_BLOCK; g++) begin
                    r_data[w_set][r_victim][g] <= mem_rdata[g*DATA_WIDTH +: DATA_WIDTH];
                end
            end
        end
    end

`ifdef CACHE_STATS_EN
    logic        r_replay;
    logic [31:0] r_hit_count;
    logic [31:0] r_miss_count;

    // Saturating counters; the hit that replays a just-filled access is not counted
    always_ff @(posedge clk) begin
        if (rst) begin
            r_replay     <= 1'b0;
            r_hit_count  <= '0;
            r_miss_count <= '0;
        end else begin
            r_replay <= (r_state == c_REFILL) && mem_ready;
            if (hit && !r_replay && (r_hit_count != 32'hFFFF_FFFF)) begin
                r_hit_count <= r_hit_count + 32'd1;
            end
            if (w_miss && (r_miss_count != 32'hFFFF_FFFF)) begin
                r_miss_count <= r_miss_count + 32'd1;
            end
        end
    end

    assign hit_count  = r_hit_count;
    assign miss_count = r_miss_count;
`endif

endmodule
`default_nettype wire

// File: tb/tb_cache_nway_wb.sv
`default_nettype none
// ============================================================================
// Module   : tb_cache_nway_wb
// Purpose  : Self-checking bench for cache_nway_wb. A timestamp-LRU cache model
//            and a sparse memory model predict every cycle's outputs; directed
//            scenarios add literal expectations. Define CACHE_STATS_EN to
//            also check the counters.
// Revision : 1.0 - initial release
// ============================================================================
module tb_cache_nway_wb;

    localparam int c_NW  = 2;
    localparam int c_NS  = 4;
    localparam int c_WPB = 4;
    localparam int c_LW  = 32 * c_WPB;

    logic            clk = 1'b0;
    logic            rst = 1'b1;
    logic            rd_en = 1'b0;
    logic            wr_en = 1'b0;
    logic [31:0]     addr = '0;
    logic [31:0]     WriteData = '0;
    logic [2:0]      funct3 = 3'b010;
    logic [31:0]     cache_read;
    logic            hit, stall, mem_req, mem_we;
    logic            mem_ready = 1'b0;
    logic [31:0]     mem_addr;
    logic [c_LW-1:0] mem_wdata;
    logic [c_LW-1:0] mem_rdata = '0;
`ifdef CACHE_STATS_EN
    logic [31:0]     hit_count, miss_count;
`endif

    always #5 clk = ~clk;

    cache_nway_wb #(
        .DATA_WIDTH(32), .ADDR_WIDTH(32), .NUM_WAYS(c_NW),
        .NUM_SETS(c_NS), .WORDS_PER_BLOCK(c_WPB)
    ) u_dut (
        .clk(clk), .rst(rst), .rd_en(rd_en), .wr_en(wr_en), .addr(addr),
        .WriteData(WriteData), .funct3(funct3), .cache_read(cache_read),
        .hit(hit), .stall(stall), .mem_req(mem_req), .mem_we(mem_we),
        .mem_addr(mem_addr), .mem_wdata(mem_wdata), .mem_ready(mem_ready),
        .mem_rdata(mem_rdata)
`ifdef CACHE_STATS_EN
        , .hit_count(hit_count), .miss_count(miss_count)
`endif
    );

    int n_cmp  = 0;
    int n_fail = 0;

    // Per-cycle expectations, consumed by the compare process
    logic            chk_en = 1'b0;
    logic            e_hit = 1'b0, e_stall = 1'b0, e_req = 1'b0, e_we = 1'b0, e_rd_chk = 1'b0;
    logic [31:0]     e_addr = '0, e_rd = '0;
    logic [c_LW-1:0] e_wdata = '0;

    // Observations of the memory port, compared against literals in directed tests
    logic [31:0] cap_wb_addr = '0, cap_wb_w0 = '0, cap_rf_addr = '0;
    int          stall_cycles = 0;
    int          wb_cycles = 0;

    // Reference model: timestamp LRU over valid lines, sparse backing memory
    logic        m_valid [c_NS][c_NW];
    logic        m_dirty [c_NS][c_NW];
    logic [25:0] m_tag   [c_NS][c_NW];
    logic [31:0] m_data  [c_NS][c_NW][c_WPB];
    int          m_used  [c_NS][c_NW];
    int          m_time;
    int          m_hits, m_misses;
    logic [31:0] mem [logic [31:0]];

    logic [2:0] ld_tab [5] = '{3'b000, 3'b001, 3'b010, 3'b100, 3'b101};
    logic [2:0] st_tab [5] = '{3'b000, 3'b001, 3'b010, 3'b011, 3'b111};

    task automatic check(input string name, input logic [c_LW-1:0] act, input logic [c_LW-1:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h, want 0x%0h (t=%0t)", name, act, exp, $time);
        end
    endtask

    function automatic logic [31:0] mem_rd(input logic [31:0] a);
        if (mem.exists(a)) return mem[a];
        return (a * 32'h9E3779B1) ^ 32'h5A5A0000;
    endfunction

    function automatic logic [31:0] load_fmt(input logic [31:0] w, input logic [1:0] b, input logic [2:0] f3);
        logic [7:0]  by;
        logic [15:0] hw;
        by = 8'(w >> (8 * b));
        hw = 16'(w >> (16 * b[1]));
        case (f3)
            3'b000:  return {{24{by[7]}}, by};
            3'b001:  return {{16{hw[15]}}, hw};
            3'b100:  return {24'b0, by};
            3'b101:  return {16'b0, hw};
            default: return w;
        endcase
    endfunction

    function automatic logic [31:0] store_merge(input logic [31:0] w, input logic [31:0] d,
                                                input logic [1:0] b, input logic [2:0] f3);
        logic [31:0] mask;
        case (f3)
            3'b000: begin
                mask = 32'hFF << (8 * b);
                return (w & ~mask) | ((d & 32'hFF) << (8 * b));
            end
            3'b001: begin
                mask = 32'hFFFF << (16 * b[1]);
                return (w & ~mask) | ((d & 32'hFFFF) << (16 * b[1]));
            end
            default: return d;
        endcase
    endfunction

    function automatic void model_reset();
        for (int s = 0; s < c_NS; s++)
            for (int w = 0; w < c_NW; w++) begin
                m_valid[s][w] = 1'b0;
                m_dirty[s][w] = 1'b0;
                m_used[s][w]  = 0;
            end
        m_time   = 0;
        m_hits   = 0;
        m_misses = 0;
    endfunction

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic set_exp(input logic h, input logic s, input logic rq, input logic we,
                           input logic [31:0] a, input logic [c_LW-1:0] wd,
                           input logic rc, input logic [31:0] rd);
        e_hit = h; e_stall = s; e_req = rq; e_we = we;
        e_addr = a; e_wdata = wd; e_rd_chk = rc; e_rd = rd;
    endtask

    // Compare process: DUT outputs against the model's expectation for this cycle
    always @(negedge clk) begin
        if (chk_en) begin
            check("hit", c_LW'(hit), c_LW'(e_hit));
            check("stall", c_LW'(stall), c_LW'(e_stall));
            check("mem_req", c_LW'(mem_req), c_LW'(e_req));
            if (e_req) begin
                check("mem_we", c_LW'(mem_we), c_LW'(e_we));
                check("mem_addr", c_LW'(mem_addr), c_LW'(e_addr));
                if (e_we) check("mem_wdata", mem_wdata, e_wdata);
            end
            if (e_rd_chk) check("cache_read", c_LW'(cache_read), c_LW'(e_rd));
        end
        if (stall) stall_cycles++;
        if (mem_req && mem_we) begin
            cap_wb_addr = mem_addr;
            cap_wb_w0   = mem_wdata[31:0];
            wb_cycles++;
        end
        if (mem_req && !mem_we) cap_rf_addr = mem_addr;
    end

    task automatic idle();
        step();
        rd_en = 1'b0;
        wr_en = 1'b0;
        set_exp(1'b0, 1'b0, 1'b0, 1'b0, '0, '0, 1'b1, '0);
    endtask

    task automatic do_reset();
        step();
        chk_en = 1'b0; rst = 1'b1; rd_en = 1'b0; wr_en = 1'b0; mem_ready = 1'b0;
        step();
        rst = 1'b0;
        model_reset();
        set_exp(1'b0, 1'b0, 1'b0, 1'b0, '0, '0, 1'b1, '0);
        chk_en = 1'b1;
        @(negedge clk);
        check("rst_mem_we", c_LW'(mem_we), '0);
        check("rst_mem_addr", c_LW'(mem_addr), '0);
        check("rst_mem_wdata", mem_wdata, '0);
`ifdef CACHE_STATS_EN
        check("rst_hit_count", c_LW'(hit_count), '0);
        check("rst_miss_count", c_LW'(miss_count), '0);
`endif
    endtask

    // One complete access: miss cycle, optional write-back, refill, then the hit cycle
    task automatic access(input logic we, input logic re, input logic [31:0] a,
                          input logic [31:0] d, input logic [2:0] f3);
        int s, wi, hw, v, lat;
        logic [25:0]     t;
        logic [31:0]     base;
        logic [c_LW-1:0] line;
        s = int'(a[5:4]); wi = int'(a[3:2]); t = a[31:6]; hw = -1;
        for (int w = 0; w < c_NW; w++)
            if (m_valid[s][w] && m_tag[s][w] == t) hw = w;
        step();
        rd_en = re; wr_en = we; addr = a; WriteData = d; funct3 = f3;
        if (hw < 0) begin
            m_misses++;
            v = -1;
            for (int w = c_NW - 1; w >= 0; w--)
                if (!m_valid[s][w]) v = w;
            if (v < 0) begin
                v = 0;
                for (int w = 1; w < c_NW; w++)
                    if (m_used[s][w] < m_used[s][v]) v = w;
            end
            set_exp(1'b0, 1'b1, 1'b0, 1'b0, '0, '0, 1'b0, '0);
            if (m_valid[s][v] && m_dirty[s][v]) begin
                base = {m_tag[s][v], 2'(s), 4'b0};
                for (int i = 0; i < c_WPB; i++) line[32*i +: 32] = m_data[s][v][i];
                lat = $urandom_range(0, 3);
                for (int c = 0; c <= lat; c++) begin
                    step();
                    mem_ready = (c == lat);
                    set_exp(1'b0, 1'b1, 1'b1, 1'b1, base, line, 1'b0, '0);
                end
                for (int i = 0; i < c_WPB; i++) mem[base + 32'(4*i)] = m_data[s][v][i];
            end
            base = {t, 2'(s), 4'b0};
            for (int i = 0; i < c_WPB; i++) line[32*i +: 32] = mem_rd(base + 32'(4*i));
            lat = $urandom_range(0, 3);
            for (int c = 0; c <= lat; c++) begin
                step();
                mem_ready = (c == lat);
                mem_rdata = line;
                set_exp(1'b0, 1'b1, 1'b1, 1'b0, base, '0, 1'b0, '0);
            end
            m_valid[s][v] = 1'b1;
            m_dirty[s][v] = 1'b0;
            m_tag[s][v]   = t;
            for (int i = 0; i < c_WPB; i++) m_data[s][v][i] = line[32*i +: 32];
            hw = v;
            step();
            mem_ready = 1'b0;
        end else begin
            m_hits++;
        end
        set_exp(1'b1, 1'b0, 1'b0, 1'b0, '0, '0, !we, load_fmt(m_data[s][hw][wi], a[1:0], f3));
        if (we) begin
            m_data[s][hw][wi] = store_merge(m_data[s][hw][wi], d, a[1:0], f3);
            m_dirty[s][hw]    = 1'b1;
        end
        m_time++;
        m_used[s][hw] = m_time;
    endtask

    initial begin
        #1_000_000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        int st0, wb0;
        model_reset();
        do_reset();

        // Cold load then 0-cycle read of the refilled word
        mem[32'h100] = 32'hDEADBEEF;
        access(1'b0, 1'b1, 32'h100, '0, 3'b010);
        @(negedge clk);
        check("cold_lw_data", c_LW'(cache_read), c_LW'(32'hDEADBEEF));
        check("cold_lw_refill_addr", c_LW'(cap_rf_addr), c_LW'(32'h100));

        // Byte store into resident line, signed and unsigned byte loads
        st0 = stall_cycles;
        access(1'b1, 1'b0, 32'h101, 32'h80, 3'b000);
        access(1'b0, 1'b1, 32'h101, '0, 3'b000);
        @(negedge clk);
        check("lb_lit", c_LW'(cache_read), c_LW'(32'hFFFFFF80));
        access(1'b0, 1'b1, 32'h101, '0, 3'b100);
        @(negedge clk);
        check("lbu_lit", c_LW'(cache_read), c_LW'(32'h00000080));
        check("sb_lb_no_stall", c_LW'(stall_cycles - st0), '0);

        // LRU with clean victim
        do_reset();
        access(1'b0, 1'b1, 32'h000, '0, 3'b010);
        access(1'b0, 1'b1, 32'h040, '0, 3'b010);
        access(1'b0, 1'b1, 32'h000, '0, 3'b010);
        wb0 = wb_cycles;
        access(1'b0, 1'b1, 32'h080, '0, 3'b010);
        check("lru_refill_addr", c_LW'(cap_rf_addr), c_LW'(32'h080));
        check("lru_no_wb", c_LW'(wb_cycles - wb0), '0);
        st0 = stall_cycles;
        access(1'b0, 1'b1, 32'h000, '0, 3'b010);
        @(negedge clk);
        check("lru_keep_hit", c_LW'(stall_cycles - st0), '0);

        // Dirty eviction
        access(1'b1, 1'b0, 32'h040, 32'h12345678, 3'b010);
        access(1'b0, 1'b1, 32'h000, '0, 3'b010);
        access(1'b0, 1'b1, 32'h080, '0, 3'b010);
        check("wb_addr_lit", c_LW'(cap_wb_addr), c_LW'(32'h040));
        check("wb_word0_lit", c_LW'(cap_wb_w0), c_LW'(32'h12345678));
        check("wb_then_refill", c_LW'(cap_rf_addr), c_LW'(32'h080));

        // Reset in the middle of a refill
        do_reset();
        step();
        rd_en = 1'b1; wr_en = 1'b0; addr = 32'h200; funct3 = 3'b010;
        set_exp(1'b0, 1'b1, 1'b0, 1'b0, '0, '0, 1'b0, '0);
        step();
        set_exp(1'b0, 1'b1, 1'b1, 1'b0, 32'h200, '0, 1'b0, '0);
        step();
        rst = 1'b1; rd_en = 1'b0;
        set_exp(1'b0, 1'b0, 1'b1, 1'b0, 32'h200, '0, 1'b0, '0);
        step();
        rst = 1'b0;
        model_reset();
        set_exp(1'b0, 1'b0, 1'b0, 1'b0, '0, '0, 1'b1, '0);
        @(negedge clk);
        check("rst_refill_req", c_LW'(mem_req), '0);
        check("rst_refill_stall", c_LW'(stall), '0);
        st0 = stall_cycles;
        access(1'b0, 1'b1, 32'h200, '0, 3'b010);
        check("rst_reissue_misses", c_LW'(stall_cycles - st0 >= 2), c_LW'(1));

`ifdef CACHE_STATS_EN
        do_reset();
        access(1'b0, 1'b1, 32'h100, '0, 3'b010);
        access(1'b0, 1'b1, 32'h100, '0, 3'b010);
        access(1'b0, 1'b1, 32'h104, '0, 3'b010);
        idle();
        @(negedge clk);
        check("stats_hit_lit", c_LW'(hit_count), c_LW'(2));
        check("stats_miss_lit", c_LW'(miss_count), c_LW'(1));
`endif

        // Randomised traffic across a few tags per set
        do_reset();
        for (int n = 0; n < 400; n++) begin
            logic [31:0] a;
            logic [2:0]  f3;
            logic        we, re;
            a  = 32'($urandom_range(0, 511));
            we = 1'($urandom_range(0, 1));
            f3 = we ? st_tab[$urandom_range(0, 4)] : ld_tab[$urandom_range(0, 4)];
            if (f3 == 3'b001 || f3 == 3'b101) a[0] = 1'b0;
            if (f3 == 3'b010 || f3 == 3'b011 || f3 == 3'b111) a[1:0] = 2'b00;
            re = we ? 1'($urandom_range(0, 1)) : 1'b1;
            access(we, re, a, $urandom, f3);
            if ($urandom_range(0, 3) == 0) idle();
        end
        idle();
        @(negedge clk);
`ifdef CACHE_STATS_EN
        check("stats_hits_rand", c_LW'(hit_count), c_LW'(m_hits));
        check("stats_miss_rand", c_LW'(miss_count), c_LW'(m_misses));
`endif
        chk_en = 1'b0;
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
        $finish;
    end

endmodule
`default_nettype wire
